// File: rtl/parity_frame_gen_pkg.sv
// Shared definitions for the parity frame generator and its downstream checker bench.
package parity_frame_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Returns 1 when the word has an odd number of ones, so appending it gives even parity.
  function automatic logic parity4(input logic [3:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_frame_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module parity_frame_timer
  import parity_frame_gen_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/parity_frame_gen.sv
// Accepts a 4-bit word, presents {a,b,c,d,p} for HOLD_CYCLES cycles, then idles for GAP_CYCLES.
module parity_frame_gen
  import parity_frame_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             inject_err,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             p,
  output logic             frame_valid,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int HOLD_LOAD = HOLD_CYCLES - 1;
  localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int MAX_LOAD  = (HOLD_LOAD > GAP_LOAD) ? HOLD_LOAD : GAP_LOAD;
  localparam int TIMER_W   = (MAX_LOAD > 0) ? $clog2(MAX_LOAD + 1) : 1;

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_done;

  assign accept = in_valid && in_ready;

  parity_frame_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The shared timer is reloaded on entry to HOLD and again on entry to GAP.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = HOLD;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(HOLD_LOAD);
        end
      end
      HOLD: begin
        if (timer_done) begin
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next  = GAP;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(GAP_LOAD);
          end
        end
      end
      GAP: begin
        if (timer_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE) && !rst;
    frame_valid = (state == HOLD);
  end

  // Frame bits persist through GAP and IDLE until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      {a, b, c, d} <= 4'b0000;
      p            <= 1'b0;
    end else if (accept) begin
      {a, b, c, d} <= in_data;
      p            <= parity4(in_data) ^ inject_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
      err_cnt   <= err_cnt + CNT_W'(inject_err);
    end
  end

endmodule

// File: doc/parity_frame_gen.md
Name: parity_frame_gen

Overview:
- Upstream stage of the 4-bit even-parity checker (`boolean`: inputs a, b, c, d, p; output e).
- Accepts a 4-bit data word over a valid/ready handshake and computes even parity.
- Drives the registered frame {a, b, c, d, p} for a fixed number of cycles, then enforces an idle gap.
- Optional single-frame parity-error injection lets the checker's e output be exercised deliberately; frame and injected-error counters support bench checking.

Parameters:
- HOLD_CYCLES, 4: cycles a frame is presented with frame_valid=1; legal range >=1.
- GAP_CYCLES, 1: idle cycles after HOLD before the next accept; 0 skips GAP.
- CNT_W, 8: width of frame_cnt and err_cnt.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept; high only in IDLE and not in reset.
- in_data  input  4  data word; bit3->a, bit2->b, bit1->c, bit0->d.
- inject_err  input  1  sampled at accept; 1 inverts p for that frame.
- a, b, c, d  output  1 each  registered frame data bits to the checker.
- p  output  1  registered parity bit to the checker.
- frame_valid  output  1  frame on a..p is current.
- frame_cnt  output  CNT_W  accepted frames, wraps modulo 2^CNT_W.
- err_cnt  output  CNT_W  accepted frames with inject_err=1, wraps.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE, a=b=c=d=p=0, frame_valid=0, frame_cnt=0, err_cnt=0, hold/gap counter=0. in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst, combinational from state.
- Accept occurs at an edge where in_valid && in_ready. At that edge:
  - {a,b,c,d} <= in_data.
  - p <= ^in_data ^ inject_err.
  - frame_cnt += 1; err_cnt += inject_err.
  - state <= HOLD; counter <= HOLD_CYCLES-1.
- Parity: with inject_err=0, a^b^c^d^p == 0 always (even parity), so checker e=0. With inject_err=1 the XOR is 1, so e=1.
- Latency: outputs reflect the accepted word from the cycle after the accept edge.
- HOLD: frame_valid=1 for exactly HOLD_CYCLES cycles, counter decrementing each cycle.
  - At counter==0: go to GAP (counter <= GAP_CYCLES-1), or to IDLE if GAP_CYCLES==0.
- GAP: frame_valid=0, a..p hold their values; at counter==0 go to IDLE.
- IDLE: frame_valid=0, a..p hold the last frame.
- Throughput: with in_valid held high, accepts are exactly HOLD_CYCLES+GAP_CYCLES+1 cycles apart.
- in_valid outside IDLE is not accepted, and in_data/inject_err are ignored. Upstream must hold in_valid and in_data until in_ready (standard handshake; no drop, no duplicate).
- inject_err affects only the frame accepted on the same edge; it is not sticky.
- Counter wrap: all-ones+1 -> 0; no saturation, no flag.
- Reset mid-HOLD/GAP: aborts the frame at the next edge. All outputs and counters go to reset values, and the accept is lost.
- rst and in_valid at the same edge: reset wins, nothing is accepted.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2) and a parity function returning ^data for a 4-bit word. The checker bench reuses the same function for its reference model.
- Natural sub-module: parity_frame_timer, a loadable down-counter with terminal flag used for both HOLD and GAP.
- The FSM, frame registers and counters stay in the top module.

Test Plan:
- Reset, then in_valid=1, in_data=4'b1011, inject_err=0 -> at the cycle after accept, a,b,c,d=1,0,1,1, p=1, frame_valid=1 for 4 cycles, checker e=0, frame_cnt=1, err_cnt=0.
- in_data=4'b0110, inject_err=1 -> p=1 (true parity 0), checker e=1 for the HOLD window, err_cnt=1; next frame 4'b0110 with inject_err=0 -> p=0, e=0.
- in_valid held high, words 4'h0 then 4'hF, defaults -> second accept exactly 6 cycles after the first; in_ready low for the 5 cycles between; both frames p=0.
- in_valid pulsed during HOLD with 4'h5, then dropped -> no accept, frame_cnt unchanged, outputs keep the prior frame.
- CNT_W=2: five accepts -> frame_cnt sequence 1,2,3,0,1.
- rst asserted in 2nd HOLD cycle of frame 4'b1110 -> next cycle a..p=0, frame_valid=0, frame_cnt=0, in_ready=1 once rst deasserts.
